// File: rtl/unidade_controle.sv
// Multi-cycle controller feeding the ULA: decodes 16-bit instructions, drives operands, writes results back.
// Optional macro UNIDADE_CONTROLE_CONTADOR_EN adds the retired-instruction counter output instr_contador.
module unidade_controle #(
  parameter int NUM_REGS = 8,
  parameter int LARGURA  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LARGURA-1:0]        instr,
  input  logic                      instr_valida,
  output logic                      instr_pronto,
  output logic [2:0]                ula_opcode,
  output logic signed [LARGURA-1:0] ula_valor1,
  output logic signed [LARGURA-1:0] ula_valor2,
  input  logic signed [LARGURA-1:0] ula_resultado,
  input  logic                      ula_executou,
  output logic signed [LARGURA-1:0] saida,
  output logic                      saida_valida,
  output logic                      concluido,
  output logic                      erro
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
  ,
  output logic [15:0]               instr_contador
`endif
);

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    ESCREVE    = 3'd3,
    LIMPA      = 3'd4
  } estado_t;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  estado_t                    estado_r;
  logic [LARGURA-1:0]         instr_r;
  logic signed [LARGURA-1:0]  banco_r [NUM_REGS];
  logic signed [LARGURA-1:0]  resultado_r;
  logic                       executou_r;
  logic [2:0]                 limpa_r;

  logic [2:0]                 op_s;
  logic [2:0]                 rd_s;
  logic [2:0]                 rs1_s;
  logic [2:0]                 rs2_s;
  logic signed [LARGURA-1:0]  imm10_s;
  logic signed [LARGURA-1:0]  imm7_s;

  assign op_s    = instr_r[15:13];
  assign rd_s    = instr_r[12:10];
  assign rs1_s   = instr_r[9:7];
  assign rs2_s   = instr_r[6:4];
  assign imm10_s = {{(LARGURA-10){instr_r[9]}}, instr_r[9:0]};
  assign imm7_s  = {{(LARGURA-7){instr_r[6]}}, instr_r[6:0]};

  // Controller FSM, register bank and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r     <= OCIOSO;
      instr_r      <= {LARGURA{1'b0}};
      resultado_r  <= {LARGURA{1'b0}};
      executou_r   <= 1'b0;
      limpa_r      <= 3'd0;
      instr_pronto <= 1'b1;
      ula_opcode   <= 3'd0;
      ula_valor1   <= {LARGURA{1'b0}};
      ula_valor2   <= {LARGURA{1'b0}};
      saida        <= {LARGURA{1'b0}};
      saida_valida <= 1'b0;
      concluido    <= 1'b0;
      erro         <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        banco_r[i] <= {LARGURA{1'b0}};
      end
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
      instr_contador <= 16'd0;
`endif
    end else begin
      concluido    <= 1'b0;
      erro         <= 1'b0;
      saida_valida <= 1'b0;
      case (estado_r)
        OCIOSO: begin
          if (instr_valida && instr_pronto) begin
            instr_r      <= instr;
            instr_pronto <= 1'b0;
            limpa_r      <= 3'd0;
            estado_r     <= (instr[15:13] == OP_CLEAR) ? LIMPA : DECODIFICA;
          end
        end
        DECODIFICA: begin
          case (op_s)
            OP_LOAD: begin
              ula_valor1 <= {LARGURA{1'b0}};
              ula_valor2 <= imm10_s;
            end
            OP_ADDI, OP_SUBI: begin
              ula_valor1 <= banco_r[rs1_s];
              ula_valor2 <= imm7_s;
            end
            default: begin
              ula_valor1 <= banco_r[rs1_s];
              ula_valor2 <= banco_r[rs2_s];
            end
          endcase
          // DISPLAY presents a neutral opcode to the ULA; its result is discarded
          ula_opcode <= (op_s == OP_DISPLAY) ? 3'b000 : op_s;
          estado_r   <= EXECUTA;
        end
        EXECUTA: begin
          resultado_r <= ula_resultado;
          executou_r  <= ula_executou;
          estado_r    <= ESCREVE;
        end
        ESCREVE: begin
          if (op_s == OP_DISPLAY) begin
            saida        <= banco_r[rd_s];
            saida_valida <= 1'b1;
          end else if (executou_r) begin
            banco_r[rd_s] <= resultado_r;
          end else begin
            erro <= 1'b1;
          end
          concluido    <= 1'b1;
          instr_pronto <= 1'b1;
          estado_r     <= OCIOSO;
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
          instr_contador <= instr_contador + 16'd1;
`endif
        end
        LIMPA: begin
          banco_r[limpa_r] <= {LARGURA{1'b0}};
          limpa_r          <= limpa_r + 3'd1;
          if (limpa_r == 3'd7) begin
            concluido    <= 1'b1;
            instr_pronto <= 1'b1;
            estado_r     <= OCIOSO;
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
            instr_contador <= instr_contador + 16'd1;
`endif
          end
        end
        default: begin
          instr_pronto <= 1'b1;
          estado_r     <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed plan items plus random instruction streams
// checked against an architectural register-bank model and a behavioural ULA.
module tb_unidade_controle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'd0;
  logic        instr_valida = 1'b0;
  logic        instr_pronto;
  logic [2:0]  ula_opcode;
  logic [15:0] ula_valor1;
  logic [15:0] ula_valor2;
  logic [15:0] ula_resultado;
  logic        ula_executou;
  logic [15:0] saida;
  logic        saida_valida;
  logic        concluido;
  logic        erro;
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
  logic [15:0] instr_contador;
`endif

  bit          ula_ok = 1'b1;
  logic [15:0] regs_m [8];
  logic [15:0] saida_m;
  logic [15:0] cnt_m;
  int          errors = 0;
  int          checks = 0;

  unidade_controle dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .instr_valida  (instr_valida),
    .instr_pronto  (instr_pronto),
    .ula_opcode    (ula_opcode),
    .ula_valor1    (ula_valor1),
    .ula_valor2    (ula_valor2),
    .ula_resultado (ula_resultado),
    .ula_executou  (ula_executou),
    .saida         (saida),
    .saida_valida  (saida_valida),
    .concluido     (concluido),
    .erro          (erro)
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
    ,
    .instr_contador(instr_contador)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ULA: combinational result, executou controlled by the bench
  always_comb begin
    case (ula_opcode)
      3'd0, 3'd1, 3'd2: ula_resultado = ula_valor1 + ula_valor2;
      3'd3, 3'd4:       ula_resultado = ula_valor1 - ula_valor2;
      3'd5:             ula_resultado = ula_valor1 * ula_valor2;
      default:          ula_resultado = 16'd0;
    endcase
    ula_executou = ula_ok;
  end

  function automatic logic [15:0] model_result(input logic [15:0] ins);
    logic [15:0] a, b, i10, i7;
    a   = regs_m[ins[9:7]];
    b   = regs_m[ins[6:4]];
    i10 = {{6{ins[9]}}, ins[9:0]};
    i7  = {{9{ins[6]}}, ins[6:0]};
    case (ins[15:13])
      3'd0:    return i10;
      3'd1:    return a + b;
      3'd2:    return a + i7;
      3'd3:    return a - b;
      3'd4:    return a - i7;
      3'd5:    return a * b;
      default: return 16'd0;
    endcase
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 8; r++) regs_m[r] = 16'd0;
    saida_m = 16'd0;
    cnt_m   = 16'd0;
  endtask

  task automatic run_instr(input logic [15:0] ins, input bit ok);
    logic [2:0]  op, rd, e_opc;
    logic [15:0] e_v1, e_v2, res;
    int          w;
    op    = ins[15:13];
    rd    = ins[12:10];
    e_opc = (op == 3'd7) ? 3'd0 : op;
    e_v1  = regs_m[ins[9:7]];
    e_v2  = regs_m[ins[6:4]];
    if (op == 3'd0) begin
      e_v1 = 16'd0;
      e_v2 = {{6{ins[9]}}, ins[9:0]};
    end else if (op == 3'd2 || op == 3'd4) begin
      e_v2 = {{9{ins[6]}}, ins[6:0]};
    end
    res = model_result(ins);
    w = 0;
    while (instr_pronto !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (instr_pronto !== 1'b1) begin
      errors++;
      $display("FAIL pronto_timeout: instr_pronto=%b required 1", instr_pronto);
    end
    ula_ok = ok;
    instr = ins;
    instr_valida = 1'b1;
    @(negedge clk);
    instr_valida = 1'b0;
    instr = 16'($urandom);
    if (op == 3'd6) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (instr_pronto !== 1'b0 || concluido !== 1'b0) begin
          errors++;
          $display("FAIL clear_busy cycle %0d: pronto=%b concluido=%b required 0 0", i, instr_pronto, concluido);
        end
        @(negedge clk);
      end
      for (int r = 0; r < 8; r++) regs_m[r] = 16'd0;
    end else begin
      checks++;
      if (instr_pronto !== 1'b0) begin
        errors++;
        $display("FAIL decode_busy: instr_pronto=%b required 0", instr_pronto);
      end
      @(negedge clk);
      checks++;
      if (ula_opcode !== e_opc) begin
        errors++;
        $display("FAIL ula_opcode instr=%h: got %0d required %0d", ins, ula_opcode, e_opc);
      end
      if (op != 3'd7) begin
        checks++;
        if (ula_valor1 !== e_v1 || ula_valor2 !== e_v2) begin
          errors++;
          $display("FAIL ula_operands instr=%h: got %h %h required %h %h", ins, ula_valor1, ula_valor2, e_v1, e_v2);
        end
      end
      @(negedge clk);
      checks++;
      if (concluido !== 1'b0 || instr_pronto !== 1'b0) begin
        errors++;
        $display("FAIL write_busy: concluido=%b pronto=%b required 0 0", concluido, instr_pronto);
      end
      @(negedge clk);
      if (op == 3'd7) saida_m = regs_m[rd];
      else if (ok) regs_m[rd] = res;
      checks++;
      if (erro !== (op != 3'd7 && !ok)) begin
        errors++;
        $display("FAIL erro instr=%h: got %b required %b", ins, erro, (op != 3'd7 && !ok));
      end
      checks++;
      if (saida_valida !== (op == 3'd7)) begin
        errors++;
        $display("FAIL saida_valida instr=%h: got %b required %b", ins, saida_valida, (op == 3'd7));
      end
    end
    cnt_m = cnt_m + 16'd1;
    checks++;
    if (concluido !== 1'b1 || instr_pronto !== 1'b1) begin
      errors++;
      $display("FAIL retire instr=%h: concluido=%b pronto=%b required 1 1", ins, concluido, instr_pronto);
    end
    checks++;
    if (saida !== saida_m) begin
      errors++;
      $display("FAIL saida instr=%h: got %h required %h", ins, saida, saida_m);
    end
`ifdef UNIDADE_CONTROLE_CONTADOR_EN
    checks++;
    if (instr_contador !== cnt_m) begin
      errors++;
      $display("FAIL contador: got %0d required %0d", instr_contador, cnt_m);
    end
`endif
    ula_ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_valida = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_model();
    checks++;
    if (instr_pronto !== 1'b1 || concluido !== 1'b0 || erro !== 1'b0 || saida_valida !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: pronto=%b concluido=%b erro=%b sv=%b required 1 0 0 0",
               instr_pronto, concluido, erro, saida_valida);
    end
    checks++;
    if (saida !== 16'd0 || ula_opcode !== 3'd0 || ula_valor1 !== 16'd0 || ula_valor2 !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: saida=%h op=%0d v1=%h v2=%h required 0", saida, ula_opcode, ula_valor1, ula_valor2);
    end
  endtask

  task automatic test_directed();
    run_instr(16'h0405, 1'b1);
    run_instr(16'hE400, 1'b1);
    checks++;
    if (saida !== 16'h0005) begin errors++; $display("FAIL disp_r1: got %h required 0005", saida); end
    run_instr(16'h48FD, 1'b1);
    run_instr(16'hACA0, 1'b1);
    run_instr(16'hEC00, 1'b1);
    checks++;
    if (saida !== 16'h000A) begin errors++; $display("FAIL disp_r3: got %h required 000A", saida); end
    run_instr(16'h7110, 1'b1);
    run_instr(16'h0600, 1'b1);
    run_instr(16'hF000, 1'b1);
    checks++;
    if (saida !== 16'hFFFD) begin errors++; $display("FAIL disp_r4: got %h required FFFD", saida); end
    run_instr(16'hE400, 1'b1);
    checks++;
    if (saida !== 16'hFE00) begin errors++; $display("FAIL disp_r1_neg: got %h required FE00", saida); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] list [5];
    int low, w;
    list[0] = 16'h0405; list[1] = 16'h0803; list[2] = 16'h34A0; list[3] = 16'h48FD; list[4] = 16'h5D10;
    w = 0;
    while (instr_pronto !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    instr_valida = 1'b1;
    for (int k = 0; k < 5; k++) begin
      instr = list[k];
      @(negedge clk);
      regs_m[list[k][12:10]] = model_result(list[k]);
      cnt_m = cnt_m + 16'd1;
      low = 0;
      while (instr_pronto !== 1'b1 && low < 20) begin low++; @(negedge clk); end
      checks++;
      if (low != 3 || concluido !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gap k=%0d: low=%0d concluido=%b required 3 1", k, low, concluido);
      end
    end
    instr_valida = 1'b0;
    for (int r = 1; r < 7; r++) run_instr({3'd7, 3'(r), 10'd0}, 1'b1);
  endtask

  task automatic test_clear();
    run_instr(16'h1C07, 1'b1);
    run_instr(16'hC000, 1'b1);
    for (int r = 0; r < 8; r++) begin
      run_instr({3'd7, 3'(r), 10'd0}, 1'b1);
      checks++;
      if (saida !== 16'd0) begin errors++; $display("FAIL clear_r%0d: got %h required 0000", r, saida); end
    end
  endtask

  task automatic test_reset_mid();
    run_instr(16'h0405, 1'b1);
    run_instr(16'h0803, 1'b1);
    instr = 16'h34A0;
    instr_valida = 1'b1;
    @(negedge clk);
    instr_valida = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    checks++;
    if (concluido !== 1'b0 || instr_pronto !== 1'b1 || erro !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: concluido=%b pronto=%b erro=%b required 0 1 0", concluido, instr_pronto, erro);
    end
    @(negedge clk);
    checks++;
    if (concluido !== 1'b0) begin errors++; $display("FAIL reset_mid_pulse: concluido=%b required 0", concluido); end
    run_instr(16'hF400, 1'b1);
    checks++;
    if (saida !== 16'd0) begin errors++; $display("FAIL reset_mid_r5: got %h required 0000", saida); end
  endtask

  task automatic test_error();
    run_instr(16'h1807, 1'b0);
    run_instr(16'hF800, 1'b1);
    checks++;
    if (saida !== 16'd0) begin errors++; $display("FAIL err_nowrite: got %h required 0000", saida); end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int n = 0; n < 48; n++) begin
      ins = 16'($urandom);
      if (ins[15:13] == 3'd6 && $urandom_range(0, 3) != 0) ins[15:13] = 3'd7;
      run_instr(ins, $urandom_range(0, 5) != 0);
    end
    for (int r = 0; r < 8; r++) run_instr({3'd7, 3'(r), 10'd0}, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_clear();
    test_error();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multi-cycle controller directly upstream of the ULA (ALU).
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Reads an internal 8x16 signed register bank, drives the ULA operand/opcode ports, samples its result and writes it back.
- Also runs two non-ALU instructions: CLEAR (zero all registers) and DISPLAY (present a register on an output port).

Parameters:
- NUM_REGS, 8, register bank depth; fixed at 8 because fields are 3 bits.
- LARGURA, 16, data and instruction width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  16  instruction word.
- instr_valida  input  1  instr is valid this cycle.
- instr_pronto  output  1  controller can accept an instruction (high only in OCIOSO).
- ula_opcode  output  3  opcode to the ULA.
- ula_valor1  output  16  signed first operand to the ULA.
- ula_valor2  output  16  signed second operand / immediate to the ULA.
- ula_resultado  input  16  signed result from the ULA (combinational).
- ula_executou  input  1  ULA reports a valid operation.
- saida  output  16  DISPLAY value, held until the next DISPLAY or reset.
- saida_valida  output  1  one-cycle pulse when saida updates.
- concluido  output  1  one-cycle pulse when an instruction retires.
- erro  output  1  one-cycle pulse when an ALU instruction is rejected.

Behaviour:
- Clock and reset
  - One clock, clk; synchronous active-high reset named reset.
  - While reset is high at a rising edge: FSM goes to OCIOSO and all 8 registers go to 0.
  - Also cleared: saida=0, saida_valida=0, concluido=0, erro=0, ula_opcode=0, ula_valor1=0, ula_valor2=0.
  - instr_pronto=1 from the first cycle after reset.
  - Reset mid-instruction aborts it: no writeback and no pulses.
- Instruction format: op=[15:13], rd=[12:10], rs1=[9:7], rs2=[6:4].
  - 000 LOAD: rd <= sext(instr[9:0]).
  - 001 ADD / 011 SUB / 101 MUL: rd <= rs1 op rs2.
  - 010 ADDI / 100 SUBI: rd <= rs1 op sext(instr[6:0]).
  - 110 CLEAR: all registers <= 0.
  - 111 DISPLAY: saida <= reg[rd].
- Handshake: transfer occurs at edge E0 when instr_valida and instr_pronto are both high.
  - instr is captured at E0; instr is ignored in every other state.
- FSM, ALU and DISPLAY path: OCIOSO -> DECODIFICA -> EXECUTA -> ESCREVE -> OCIOSO.
  - DECODIFICA (after E0): operands read from the bank and registered onto the ula_* ports at E1.
    - LOAD: ula_valor1=0, ula_valor2=immediate.
  - EXECUTA: ula_* are held; ula_resultado and ula_executou are sampled at E2.
  - ESCREVE: rd is written at E3 if the sampled ula_executou=1.
    - Otherwise there is no write and erro pulses from E3.
  - concluido pulses for the cycle after E3 in both cases; instr_pronto is high again in that same cycle.
  - Throughput: one instruction per 4 cycles.
- DISPLAY follows the same state path, but ula_opcode is driven to 000 and ula_executou is ignored.
  - At E3: saida <= reg[rd] and saida_valida pulses; no register write.
- CLEAR: OCIOSO -> LIMPA.
  - One register is zeroed per edge (index 0..7) on edges E1..E8 using a 3-bit counter.
  - Return to OCIOSO at E8; concluido pulses after E8.
  - instr_pronto stays low throughout.
- Arithmetic: two's complement, truncated to 16 bits by the ULA; no overflow detection.
- Read-after-write: an instruction accepted right after a writeback reads the updated value (sequential, no hazard).
- rd = rs1 = rs2 is legal: operands are read in DECODIFICA before the write in ESCREVE.

Optional Feature:
- Macro: UNIDADE_CONTROLE_CONTADOR_EN.
- Defined: adds output instr_contador (16 bits).
  - Reset to 0; increments on every concluido pulse, including ones with erro.
  - Wraps 0xFFFF -> 0x0000.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then instr=0x0405 (LOAD r1,5) -> concluido 4 cycles after accept; DISPLAY r1 (0xE400) -> saida=0x0005, saida_valida pulse.
- Then 0x48FD (ADDI r2,r1,-3) -> r2=2; 0xACA0 (MUL r3,r1,r2) -> r3=10; DISPLAY r3 (0xEC00) -> saida=0x000A.
- 0x7110 (SUB r4,r2,r1) -> r4=0xFFFD; then 0x0600 (LOAD r1,-512) -> r1=0xFE00. Check ula_valor1=0 and ula_valor2=0xFE00 during EXECUTA of the LOAD.
- Hold instr_valida high back-to-back -> instr_pronto low for 3 cycles per instruction; no instruction lost or duplicated.
- Issue CLEAR (0xC000) -> instr_pronto low for 8 cycles; all DISPLAYs r0..r7 return 0.
- Assert reset during EXECUTA of ADD r5 -> r5 unchanged (0), no concluido, instr_pronto=1 next cycle.
- Force ula_executou=0 in EXECUTA -> erro pulse, no write, concluido pulse.
- With UNIDADE_CONTROLE_CONTADOR_EN defined -> instr_contador counts retirements and wraps from 0xFFFF to 0x0000.
